// File: rtl/mem_stream_mux.sv
// Tagged, flow-controlled read mux: arbitrates NCH memory ports onto one stream with per-BX headers.
// Optional feature: define MEM_STREAM_RR_EN for round-robin arbitration (default is fixed priority).
module mem_stream_mux #(
  parameter int unsigned NCH = 12,
  parameter int unsigned DW  = 44,
  parameter int unsigned SW  = 4,
  parameter int unsigned BXW = 3,
  parameter int unsigned CW  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCH-1:0]    i_ch_valid,
  input  logic [NCH*DW-1:0] i_ch_data,
  output logic [NCH-1:0]    o_ch_ack,
  input  logic              i_bx_start,
  input  logic [BXW-1:0]    i_bx_in,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [SW+DW-1:0]  o_out_data,
  output logic [CW-1:0]     o_frame_cnt,
  output logic              o_hdr_overrun
);

  localparam int unsigned OW = SW + DW;
  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {S_RUN, S_HDR} state_t;

  state_t         r_state, w_state_nxt;
  logic [BXW-1:0] r_hdr_bx, w_hdr_bx_nxt;
  logic           r_out_valid, w_out_valid_nxt;
  logic [OW-1:0]  r_out_data, w_out_data_nxt;
  logic [CW-1:0]  r_frame_cnt, w_frame_cnt_nxt;
  logic           r_hdr_overrun, w_hdr_overrun_nxt;
  logic           w_load, w_any, w_hdr_take;
  logic [PW-1:0]  w_grant;
`ifdef MEM_STREAM_RR_EN
  logic [PW-1:0]  r_ptr, w_ptr_nxt;
`endif

  assign w_load = !r_out_valid || i_out_ready;

  // Arbiter: descending scan so the last hit (closest to the start point) wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
`ifdef MEM_STREAM_RR_EN
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      int unsigned idx;
      idx = int'(r_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (i_ch_valid[idx]) begin
        w_any   = 1'b1;
        w_grant = PW'(idx);
      end
    end
`else
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (i_ch_valid[k]) begin
        w_any   = 1'b1;
        w_grant = PW'(k);
      end
    end
`endif
  end

  // Next-state, output-register and Mealy ack logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_hdr_bx_nxt      = r_hdr_bx;
    w_out_valid_nxt   = r_out_valid;
    w_out_data_nxt    = r_out_data;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_hdr_overrun_nxt = r_hdr_overrun;
    w_hdr_take        = 1'b0;
    o_ch_ack          = '0;
`ifdef MEM_STREAM_RR_EN
    w_ptr_nxt         = r_ptr;
`endif
    case (r_state)
      S_HDR: begin
        if (w_load) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = {{SW{1'b1}}, DW'(r_hdr_bx) << (DW - BXW)};
          w_frame_cnt_nxt = '0;
          w_state_nxt     = S_RUN;
          w_hdr_take      = 1'b1;
        end
      end
      default: begin
        if (w_load && w_any) begin
          o_ch_ack        = i_reset ? '0 : (NCH'(1) << w_grant);
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = {SW'(w_grant) + SW'(1), i_ch_data[w_grant*DW +: DW]};
          if (r_frame_cnt != {CW{1'b1}}) w_frame_cnt_nxt = r_frame_cnt + CW'(1);
`ifdef MEM_STREAM_RR_EN
          w_ptr_nxt = (w_grant == PW'(NCH - 1)) ? '0 : w_grant + PW'(1);
`endif
        end else if (w_load) begin
          w_out_valid_nxt = 1'b0;
          w_out_data_nxt  = '0;
        end
      end
    endcase
    // A new BX pulse always re-arms the header; it only overruns if the old one stays unsent.
    if (i_bx_start) begin
      w_hdr_bx_nxt = i_bx_in;
      w_state_nxt  = S_HDR;
      if (r_state == S_HDR && !w_hdr_take) w_hdr_overrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_RUN;
      r_hdr_bx      <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_frame_cnt   <= '0;
      r_hdr_overrun <= 1'b0;
`ifdef MEM_STREAM_RR_EN
      r_ptr         <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_hdr_bx      <= w_hdr_bx_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_data    <= w_out_data_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_hdr_overrun <= w_hdr_overrun_nxt;
`ifdef MEM_STREAM_RR_EN
      r_ptr         <= w_ptr_nxt;
`endif
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_hdr_overrun = r_hdr_overrun;

endmodule

// File: tb/tb_mem_stream_mux.sv
// Bench for mem_stream_mux: vector table with a scoreboard for emitted words, plus saturation and reset sequences.
module tb_mem_stream_mux;
  localparam int unsigned NCH = 12;
  localparam int unsigned DW  = 44;
  localparam int unsigned SW  = 4;
  localparam int unsigned BXW = 3;
  localparam int unsigned CW  = 8;
`ifdef MEM_STREAM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NCH-1:0]    ch_valid, ch_ack;
  logic [NCH*DW-1:0] ch_data;
  logic              bx_start;
  logic [BXW-1:0]    bx_in;
  logic              out_ready, out_valid;
  logic [SW+DW-1:0]  out_data;
  logic [CW-1:0]     frame_cnt;
  logic              hdr_overrun;

  mem_stream_mux #(.NCH(NCH), .DW(DW), .SW(SW), .BXW(BXW), .CW(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_ch_valid(ch_valid), .i_ch_data(ch_data),
    .o_ch_ack(ch_ack), .i_bx_start(bx_start), .i_bx_in(bx_in), .i_out_ready(out_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_frame_cnt(frame_cnt),
    .o_hdr_overrun(hdr_overrun)
  );

  // Memory model: each channel's word carries its index and a pop count.
  int ccnt [NCH];
  int checks = 0;
  int errors = 0;
  logic [SW+DW-1:0] sb [$];

  function automatic logic [DW-1:0] chword(int i);
    return DW'({8'(i), 36'(ccnt[i])});
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = chword(i);
  end

  function automatic logic [SW+DW-1:0] hdr_word(int b);
    return {{SW{1'b1}}, DW'(BXW'(b)) << (DW - BXW)};
  endfunction

  function automatic logic [NCH-1:0] bit_(int i);
    return NCH'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [NCH-1:0] v, input logic bx, input int bxn, input logic rdy,
                     output logic [NCH-1:0] ack);
    ch_valid  = v;
    bx_start  = bx;
    bx_in     = BXW'(bxn);
    out_ready = rdy;
    #4;
    ack = ch_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (ack[i]) ccnt[i]++;
  endtask

  typedef struct {
    logic [NCH-1:0] v;
    logic           bx;
    int             bxn;
    logic           rdy;
    logic [NCH-1:0] ack;
    logic           ov;
    logic           nw;
    int             code;
    int             hb;
    int             cnt;
    logic           ovr;
  } vec_t;

  function automatic vec_t mk(logic [NCH-1:0] v, logic bx, int bxn, logic rdy, logic [NCH-1:0] ack,
                              logic ov, logic nw, int code, int hb, int cnt, logic ovr);
    vec_t r;
    r.v = v; r.bx = bx; r.bxn = bxn; r.rdy = rdy; r.ack = ack; r.ov = ov;
    r.nw = nw; r.code = code; r.hb = hb; r.cnt = cnt; r.ovr = ovr;
    return r;
  endfunction

  vec_t vt [22];
  logic [NCH-1:0]   ack;
  logic [SW+DW-1:0] exp_w, last_w;

  initial begin
    for (int i = 0; i < NCH; i++) ccnt[i] = 0;
    last_w = '0;
    vt[0]  = mk('1,        0, 0, 1, bit_(0),  1, 1, 1,  0, 1, 0);
    vt[1]  = mk('0,        1, 5, 1, '0,       0, 0, 0,  0, 1, 0);
    vt[2]  = mk(bit_(3),   0, 0, 1, '0,       1, 1, 15, 5, 0, 0);
    vt[3]  = mk(bit_(3),   0, 0, 1, bit_(3),  1, 1, 4,  0, 1, 0);
    for (int k = 4; k <= 6; k++) vt[k] = mk(bit_(3), 0, 0, 0, '0, 1, 0, 0, 0, 1, 0);
    vt[7]  = mk(bit_(3),   0, 0, 1, bit_(3),  1, 1, 4,  0, 2, 0);
    vt[8]  = mk('0,        1, 6, 1, '0,       0, 0, 0,  0, 2, 0);
    vt[9]  = mk('0,        1, 7, 1, '0,       1, 1, 15, 6, 0, 0);
    vt[10] = mk(bit_(11),  0, 0, 1, '0,       1, 1, 15, 7, 0, 0);
    vt[11] = mk(bit_(11),  0, 0, 1, bit_(11), 1, 1, 12, 0, 1, 0);
    vt[12] = mk(bit_(11),  1, 2, 0, '0,       1, 0, 0,  0, 1, 0);
    vt[13] = mk(bit_(11),  1, 3, 0, '0,       1, 0, 0,  0, 1, 1);
    vt[14] = mk(bit_(11),  0, 0, 1, '0,       1, 1, 15, 3, 0, 1);
    vt[15] = mk(bit_(11),  0, 0, 1, bit_(11), 1, 1, 12, 0, 1, 1);
    vt[16] = mk('0,        0, 0, 1, '0,       0, 0, 0,  0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      int g;
      g = (RR && (k % 2 == 1)) ? 5 : 0;
      vt[17+k] = mk(bit_(0) | bit_(5), 0, 0, 1, bit_(g), 1, 1, g + 1, 0, 2 + k, 1);
    end
    vt[21] = mk('0,        0, 0, 1, '0,       0, 0, 0,  0, 5, 1);

    // Reset with every channel requesting.
    reset = 1'b1; ch_valid = '1; bx_start = 1'b0; bx_in = '0; out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      chk("rst valid", 64'(out_valid), 64'd0);
      chk("rst data", 64'(out_data), 64'd0);
      chk("rst cnt", 64'(frame_cnt), 64'd0);
      chk("rst ovr", 64'(hdr_overrun), 64'd0);
      #4;
      chk("rst ack", 64'(ch_ack), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      if (vt[i].nw) begin
        exp_w = (vt[i].code == 15) ? hdr_word(vt[i].hb)
                                   : {SW'(vt[i].code), chword(vt[i].code - 1)};
        sb.push_back(exp_w);
      end
      cyc(vt[i].v, vt[i].bx, vt[i].bxn, vt[i].rdy, ack);
      chk($sformatf("v%0d ack", i), 64'(ack), 64'(vt[i].ack));
      chk($sformatf("v%0d valid", i), 64'(out_valid), 64'(vt[i].ov));
      if (vt[i].nw) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL v%0d scoreboard: got empty queue expected one word", i);
        end else begin
          exp_w = sb.pop_front();
          chk($sformatf("v%0d data", i), 64'(out_data), 64'(exp_w));
          last_w = exp_w;
        end
      end else if (vt[i].ov) begin
        chk($sformatf("v%0d hold", i), 64'(out_data), 64'(last_w));
      end else begin
        chk($sformatf("v%0d idle", i), 64'(out_data), 64'd0);
      end
      chk($sformatf("v%0d cnt", i), 64'(frame_cnt), 64'(vt[i].cnt));
      chk($sformatf("v%0d ovr", i), 64'(hdr_overrun), 64'(vt[i].ovr));
    end

    // Frame counter saturation and clear on header.
    cyc('0, 1'b1, 1, 1'b1, ack);
    cyc('0, 1'b0, 0, 1'b1, ack);
    chk("sat hdr", 64'(out_data), 64'(hdr_word(1)));
    chk("sat cnt0", 64'(frame_cnt), 64'd0);
    for (int k = 1; k <= 300; k++) begin
      cyc(bit_(0), 1'b0, 0, 1'b1, ack);
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
        chk($sformatf("sat cnt k%0d", k), 64'(frame_cnt), 64'((k > 255) ? 255 : k));
    end
    cyc(bit_(0), 1'b1, 4, 1'b1, ack);
    chk("sat last cnt", 64'(frame_cnt), 64'd255);
    cyc(bit_(0), 1'b0, 0, 1'b1, ack);
    chk("sat clr ack", 64'(ack), 64'd0);
    chk("sat clr hdr", 64'(out_data), 64'(hdr_word(4)));
    chk("sat clr cnt", 64'(frame_cnt), 64'd0);

    // A stalled word is dropped by reset.
    cyc(bit_(0), 1'b0, 0, 1'b1, ack);
    chk("stall word", 64'(out_valid), 64'd1);
    reset = 1'b1;
    cyc(bit_(0), 1'b0, 0, 1'b0, ack);
    chk("rst2 ack", 64'(ack), 64'd0);
    chk("rst2 valid", 64'(out_valid), 64'd0);
    chk("rst2 data", 64'(out_data), 64'd0);
    chk("rst2 ovr", 64'(hdr_overrun), 64'd0);
    reset = 1'b0;
    ch_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stream_mux.md
# mem_stream_mux

Parametrised, flow-controlled successor to the fixed 12-port memory-read mux. It arbitrates among NCH memory read ports and drives one tagged output stream toward the link serialiser. Each output word is prefixed with an SW-bit source code. Each bunch crossing (BX) is framed by a header word, and downstream backpressure is honoured. Per-channel acks pop the memories, and a per-BX data-word count is kept for monitoring.

## Interface
- NCH, 12: number of input channels; 1..2^SW-2.
- DW, 44: data width per channel.
- SW, 4: source-code width.
- BXW, 3: BX number width; BXW <= DW.
- CW, 8: frame word-counter width.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ch_valid  in  NCH  channel i has a word on its data slice.
- ch_data  in  NCH*DW  flat bus; channel i occupies bits [i*DW +: DW].
- ch_ack  out  NCH  one-hot pop; the word of channel i is taken at this clock edge.
- bx_start  in  1  one-cycle pulse marking a new BX.
- bx_in  in  BXW  BX number, sampled with bx_start.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  SW+DW  {code, payload}.
- frame_cnt  out  CW  data words emitted since the last header; saturating.
- hdr_overrun  out  1  sticky: a pending header was overwritten before it was sent.

## Operation
- Output register load condition: load = !out_valid || out_ready.
- Codes:
  - 0 means idle; out_data is 0 whenever out_valid = 0.
  - Channel i is sent as code i+1.
  - All-ones is the header code.
- Header path:
  - bx_start sets hdr_pend and latches bx_in into hdr_bx.
  - If hdr_pend is already set and not being consumed this cycle, hdr_bx is overwritten and hdr_overrun is set.
- Two-state FSM:
  - RUN: arbitrate channels.
  - HDR: header pending. Entered when hdr_pend = 1.
- In HDR with load = 1:
  - out_data <= {all-ones, hdr_bx, zeros}, out_valid <= 1.
  - frame_cnt <= 0, hdr_pend <= 0, next state RUN.
  - No channel is acked that cycle.
- Header has absolute priority over data.
- If bx_start coincides with the header load, the new header becomes pending again. It is not an overrun.
- In RUN with load = 1 and any ch_valid:
  - The grant g is chosen by the arbitration policy (see Configuration).
  - ch_ack[g] = 1, combinational in the same cycle.
  - out_data <= {g+1, ch_data[g]}, out_valid <= 1.
  - frame_cnt increments and saturates at 2^CW-1.
- In RUN with load = 1 and no ch_valid: out_valid <= 0, out_data <= 0.
- With load = 0, ch_ack = 0 and all output registers hold.
- Channels must deassert ch_valid, or present the next word, on the cycle after the ack.
- Reset values: out_valid 0, out_data 0, ch_ack 0, frame_cnt 0, hdr_overrun 0, hdr_pend 0, FSM RUN, round-robin pointer 0.
- Reset has priority over all inputs. A stalled word is discarded at reset.

## Timing
- ch_valid to out_valid: 1 cycle, when load = 1.
- bx_start to header on out_data: 1 cycle, if load = 1 on the cycle after the pulse. Otherwise the header goes out at the first subsequent load.
- Throughput: one word per cycle while out_ready = 1.
- ch_ack is a Mealy output: asserted only in a cycle where load = 1 and the FSM is in RUN.
- frame_cnt and hdr_overrun update on the same edge as out_data.

## Configuration
- MEM_STREAM_RR_EN
  - Defined: round-robin arbitration. The search starts at pointer p and wraps modulo NCH. After each grant, p <= (g+1) mod NCH. Headers do not move p.
  - Undefined: fixed priority; the lowest-index valid channel wins, and there is no pointer register.

## Test plan
- Reset with ch_valid = all-ones:
  - During reset, out_valid = 0, out_data = 0 and ch_ack = 0.
  - First load after release grants channel 0: out_data = {4'h1, ch_data[0]}.
- bx_start with bx_in = 3'd5 while ch_valid[3] = 1:
  - Next cycle: out_data = {4'hF, 3'd5, 41'b0}, ch_ack = 0, frame_cnt = 0.
  - Following cycle: {4'h4, ch_data[3]}, frame_cnt = 1.
- out_ready held 0 for 3 cycles with out_valid = 1:
  - out_data is stable and ch_ack = 0 throughout.
  - On release, exactly one new word is loaded.
- Two bx_start pulses (bx 2, then bx 3) while stalled:
  - hdr_overrun = 1.
  - Only header bx = 3 is emitted.
- Channels 0 and 5 held valid for 4 loads:
  - With MEM_STREAM_RR_EN: codes 1, 6, 1, 6.
  - Without it: codes 1, 1, 1, 1.
- 300 data words in one frame with CW = 8: frame_cnt saturates at 255 and clears on the next header.
